// File: rtl/dadda_product_accumulator.sv
// Sums LEN unsigned 32-bit products taken from a Dadda multiplier's final adder
// and clamps the total at the accumulator's full scale.
module dadda_product_accumulator #(
  parameter int LEN   = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [29:0]      rca_sum,
  input  logic             rca_cout,
  input  logic [1:0]       lsb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] LEN_C = 8'(LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_out_q, acc_out_d, product, acc_next;
  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_q, cnt_d, cnt_inc;
  logic             sat_acc_q, sat_acc_d, sat_q, sat_d, err_q, err_d;
  logic             accept, ovf;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_out_q;
  assign sat       = sat_q;
  assign err       = err_q;

  // rca_cout is only monitored; a legal 16x16 product never sets it.
  assign product  = ACC_W'({rca_sum, lsb});
  assign accept   = in_valid & in_ready & ~clr;
  assign sum      = {1'b0, acc_q} + {1'b0, product};
  assign ovf      = sat_acc_q | sum[ACC_W];
  assign acc_next = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_acc_d = sat_acc_q;
    acc_out_d = acc_out_q;
    sat_d     = sat_q;
    err_d     = err_q | (accept & rca_cout);
    if (clr) begin
      state_d   = IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      sat_acc_d = 1'b0;
      sat_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          acc_d     = product;
          cnt_d     = 8'd1;
          sat_acc_d = 1'b0;
          if (LEN_C == 8'd1) begin
            state_d   = DONE;
            acc_out_d = product;
            sat_d     = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
        ACCUM: if (accept) begin
          acc_d     = acc_next;
          cnt_d     = cnt_inc;
          sat_acc_d = ovf;
          if (cnt_inc == LEN_C) begin
            state_d   = DONE;
            acc_out_d = acc_next;
            sat_d     = ovf;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
      acc_out_q <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_acc_q <= sat_acc_d;
      acc_out_q <= acc_out_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Directed bench for dadda_product_accumulator with LEN=4, ACC_W=33.
module tb_dadda_product_accumulator;

  localparam int LEN   = 4;
  localparam int ACC_W = 33;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, in_ready, rca_cout, out_valid, out_ready, sat, err;
  logic [29:0]      rca_sum;
  logic [1:0]       lsb;
  logic [ACC_W-1:0] acc_out;
  logic [ACC_W-1:0] held;

  int checks   = 0;
  int failures = 0;

  dadda_product_accumulator #(.LEN(LEN), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .rca_sum(rca_sum), .rca_cout(rca_cout), .lsb(lsb), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .sat(sat), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] v, input logic co);
    in_valid = 1'b1;
    rca_sum  = v[31:2];
    lsb      = v[1:0];
    rca_cout = co;
  endtask

  task automatic beat(input logic [31:0] v, input logic co);
    present(v, co);
    step();
    in_valid = 1'b0;
    rca_cout = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rca_sum = '0; lsb = '0; rca_cout = 1'b0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_acc_out", 64'(acc_out), 64'd0);
    chk("rst_sat_err", 64'({sat, err}), 64'd0);
    #5 rst = 1'b0;
    step();

    // four beats of 0xFFFF back-to-back
    repeat (3) beat(32'h0000_FFFF, 1'b0);
    chk("b2b_not_done", 64'(out_valid), 64'd0);
    beat(32'h0000_FFFF, 1'b0);
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_acc_out", 64'(acc_out), 64'h3_FFFC);
    chk("b2b_sat", 64'(sat), 64'd0);

    // stall in DONE with a beat pending
    present(32'd7, 1'b0);
    held = acc_out;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_acc_out", 64'(acc_out), 64'(held));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_acc_keep", 64'(acc_out), 64'h3_FFFC);
    repeat (3) step();
    chk("pending_not_done", 64'(out_valid), 64'd0);
    beat(32'd7, 1'b0);
    chk("pending_done", 64'(out_valid), 64'd1);
    chk("pending_acc_out", 64'(acc_out), 64'd28);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // exactly full scale: no clamp
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'd1, 1'b0);
    beat(32'd0, 1'b0);
    chk("edge_acc_out", 64'(acc_out), 64'h1_FFFF_FFFF);
    chk("edge_sat", 64'(sat), 64'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // overflow clamps and stays clamped
    repeat (4) beat(32'hFFFF_FFFF, 1'b0);
    chk("ovf_out_valid", 64'(out_valid), 64'd1);
    chk("ovf_acc_out", 64'(acc_out), 64'h1_FFFF_FFFF);
    chk("ovf_sat", 64'(sat), 64'd1);

    // clr in DONE
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_done_out_valid", 64'(out_valid), 64'd0);
    chk("clr_done_sat", 64'(sat), 64'd0);

    // clr mid-group discards the partial sum
    beat(32'h100, 1'b0);
    beat(32'h100, 1'b0);
    present(32'h100, 1'b0);
    clr = 1'b1; step(); clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_mid_in_ready", 64'(in_ready), 64'd1);
    chk("clr_mid_out_valid", 64'(out_valid), 64'd0);
    repeat (3) beat(32'd1, 1'b0);
    chk("clr_mid_not_done", 64'(out_valid), 64'd0);
    beat(32'd1, 1'b0);
    chk("clr_mid_acc_out", 64'(acc_out), 64'd4);
    chk("clr_mid_sat", 64'(sat), 64'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // carry-out beat: flagged and still accumulated
    chk("err_before", 64'(err), 64'd0);
    beat({30'd1, 2'b00}, 1'b1);
    chk("err_set", 64'(err), 64'd1);
    repeat (3) beat(32'd1, 1'b0);
    chk("err_acc_out", 64'(acc_out), 64'd7);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("err_after_result", 64'(err), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("err_after_clr", 64'(err), 64'd1);

    // async reset between edges mid-group
    beat(32'd5, 1'b0);
    beat(32'd5, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc_out", 64'(acc_out), 64'd0);
    chk("arst_flags", 64'({out_valid, sat, err}), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
    step();
    repeat (4) beat(32'd3, 1'b0);
    chk("arst_next_valid", 64'(out_valid), 64'd1);
    chk("arst_next_acc", 64'(acc_out), 64'd12);
    chk("arst_next_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
